seq_match_counter: RTL

SEQ_MATCH_COUNTER -- requirements
Module: seq_match_counter

---
 rtl/seq_match_counter.sv | 77 +++++++
 1 files changed

// File: rtl/seq_match_counter.sv
// seq_match_counter: serial 8-bit pattern detector with BCD match counter.
//   clk_in    - rising-edge clock
//   reset     - synchronous active-high reset
//   bit_in    - serial data bit, qualified by bit_valid
//   bit_valid - one-cycle strobe shifting bit_in into the window
//   clear     - synchronous soft clear (same effect as reset)
//   found     - one-cycle pulse per match of the window against PATTERN
//   match_bcd - four-digit BCD match count, [15:12] thousands
//   count_ovf - sticky flag, set when the count wraps from 9999
//   filled    - high once 8 valid bits have been received
module seq_match_counter #(
  parameter logic [7:0] PATTERN = 8'hB6
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clear,
  output logic        found,
  output logic [15:0] match_bcd,
  output logic        count_ovf,
  output logic        filled
);
  typedef enum logic [1:0] {EMPTY, FILL, SCAN} state_e;
  state_e      state_q, state_d;
  logic [7:0]  win_q, win_d;
  logic [3:0]  fill_q, fill_d;
  logic        found_q, found_d;
  logic [15:0] bcd_q, bcd_d, bcd_inc;
  logic        ovf_q, ovf_d;
  logic        carry;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= EMPTY;
      win_q   <= 8'h00;
      fill_q  <= 4'd0;
      found_q <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      found_q <= found_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end
  // SCAN is entered on the same edge that delivers the 8th bit, so that bit's match counts.
  always_comb begin
    fill_d  = clear ? 4'd0 : (bit_valid && fill_q != 4'd8) ? fill_q + 4'd1 : fill_q;
    state_d = clear ? EMPTY : !bit_valid ? state_q : (fill_d == 4'd8) ? SCAN : FILL;
  end
  // carry leaves the loop set only when every digit was 9, i.e. the count wraps.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++)
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) bcd_inc[4*i +: 4] = 4'd0;
        else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    win_d   = clear ? 8'h00 : bit_valid ? {win_q[6:0], bit_in} : win_q;
    found_d = !clear && bit_valid && state_d == SCAN && win_d == PATTERN;
    bcd_d   = clear ? 16'h0000 : found_d ? bcd_inc : bcd_q;
    ovf_d   = !clear && (ovf_q || (found_d && carry));
  end
  always_comb begin
    filled    = state_q == SCAN;
    found     = found_q;
    match_bcd = bcd_q;
    count_ovf = ovf_q;
  end
endmodule
